uart_sram_loader: RTL and testbench
===================================

Name: uart_sram_loader

Overview:
Parametrised byte-stream-to-SRAM loader; successor to the fixed 16-bit UART-to-SRAM writer.
- Pulls bytes from a UART receive controller through an unload handshake.
- Optionally strips N header lines, then packs BYTES_PER_WORD bytes per SRAM word.
- Writes words from a programmable start address, for a programmable word count.
- Sits between the UART receiver and the SRAM write-port mux at the top level.

Parameters:
DATA_W, 16, SRAM word width; multiple of 8, range 8..64; BYTES_PER_WORD = DATA_W/8
ADDR_W, 18, SRAM address width
HEADER_LINES, 0, number of 8'h0A bytes to discard before payload (0..7)
MSB_FIRST, 1, 1: first byte received lands in the top byte lane; 0: in lane 0

Ports:
Clock  in  1  system clock
Resetn  in  1  asynchronous active-low reset
Initialize  in  1  synchronous clear; overrides all other activity
Enable  in  1  start request; sampled only in S_IDLE
Start_address  in  ADDR_W  first word address; latched on start
Word_limit  in  ADDR_W  words to write; 0 = run to top of address space; latched on start
Rx_data  in  8  byte from UART receiver
Rx_empty  in  1  receiver has no byte available
Rx_enable  out  1  enables UART receiver
Rx_unload  out  1  byte-consumed handshake
SRAM_address  out  ADDR_W  write address
SRAM_write_data  out  DATA_W  assembled word
SRAM_we_n  out  1  active-low write strobe
Busy  out  1  high in any state other than S_IDLE/S_DONE
Done  out  1  high in S_DONE
Words_written  out  ADDR_W  count of completed writes

Behaviour:
Reset is Resetn asynchronous active-low on Clock. All outputs reset to 0, except SRAM_we_n=1. State resets to S_IDLE.
Initialize=1 forces the reset values synchronously, including state S_IDLE and the header counter.
States: S_IDLE, S_HDR_WAIT, S_HDR_ACK, S_BYTE_WAIT, S_BYTE_ACK, S_WRITE, S_DONE.
S_IDLE:
- On Enable: latch Start_address into SRAM_address; latch Word_limit.
- Set Rx_enable=1; clear Words_written, byte index and header count.
- Go to S_HDR_WAIT if HEADER_LINES>0, else S_BYTE_WAIT.
S_HDR_WAIT:
- On Rx_empty=0: set Rx_unload=1.
- If Rx_data==8'h0A, increment the header count (saturates at HEADER_LINES).
- Go to S_HDR_ACK.
S_HDR_ACK:
- On Rx_empty=1: set Rx_unload=0.
- If count==HEADER_LINES go to S_BYTE_WAIT, else S_HDR_WAIT.
S_BYTE_WAIT:
- On Rx_empty=0: set Rx_unload=1.
- Write the byte into lane (MSB_FIRST ? BYTES_PER_WORD-1-idx : idx). Other lanes hold their value.
- Go to S_BYTE_ACK.
S_BYTE_ACK:
- On Rx_empty=1: set Rx_unload=0.
- If idx==BYTES_PER_WORD-1: clear idx, set SRAM_we_n=0, go to S_WRITE. Otherwise idx+1, go to S_BYTE_WAIT.
S_WRITE (exactly one cycle, address and data stable):
- Set SRAM_we_n=1 and Words_written+1.
- If (limit!=0 && Words_written+1==limit) or SRAM_address==all-ones: keep the address, set Rx_enable=0, go to S_DONE.
- Otherwise SRAM_address+1 and go to S_BYTE_WAIT.
S_DONE: Done=1 held until Initialize, or Enable, which restarts as from S_IDLE.
Boundary conditions:
- Enable outside S_IDLE/S_DONE is ignored.
- The address never wraps.
- A partial word pending at stop is never written.
- Rx_unload is never high for more than one byte.
- Each write strobe is exactly one cycle; there is at most one write per BYTES_PER_WORD bytes.
- Initialize mid-word discards the partial word without a write.
- Undefined states return to S_IDLE.

Optional Feature:
Macro UART_SRAM_LOADER_CHECKSUM_EN.
- Defined: adds output Checksum[15:0]. It is the mod-2^16 sum of all payload bytes consumed (headers excluded), cleared on start/Initialize/reset, and updated in the cycle the byte is captured.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (existing state-type header): typedef enum uart_sram_loader_state_type with the states above, plus constant ASCII_LF=8'h0A.
- Optional sub-module byte_packer (lane select, index counter, word register), parametrised by DATA_W and MSB_FIRST.

Test Plan:
1. DATA_W=16, HEADER_LINES=0, Start=0, limit=2; bytes AB CD 12 34 -> writes 16'hABCD @0, 16'h1234 @1. Done=1, Words_written=2, two one-cycle we_n pulses.
2. HEADER_LINES=3; stream "P6\n4 4\n255\n" then 01 02 -> header discarded, single write 16'h0102 @Start.
3. DATA_W=32, MSB_FIRST=0, limit=1; bytes 11 22 33 44 -> write 32'h44332211. No write after fewer than 4 bytes.
4. Start=18'h3FFFE, limit=0; send 6 bytes -> writes @3FFFE and @3FFFF only. Stop with address 3FFFF, Rx_enable=0, third word ignored.
5. Initialize asserted after first byte of a word -> no write, all outputs at reset values, S_IDLE; subsequent Enable restarts cleanly.
6. With UART_SRAM_LOADER_CHECKSUM_EN, bytes FF FF 02 00 -> Checksum=16'h0200.

Source files
------------

// File: rtl/uart_sram_loader_pkg.sv
// Shared state type and constants for the UART byte-stream to SRAM loader.
package uart_sram_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_WAIT,
    S_HDR_ACK,
    S_BYTE_WAIT,
    S_BYTE_ACK,
    S_WRITE,
    S_DONE
  } uart_sram_loader_state_type;

  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_sram_loader_byte_packer.sv
// Packs successive bytes into a DATA_W word; MSB_FIRST puts the first byte in the top lane.
module uart_sram_loader_byte_packer #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              clear,
  input  logic              restart,
  input  logic              capture,
  input  logic              advance,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              last_lane
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] lane;

  assign last_lane = (idx == IDX_W'(BPW - 1));
  assign lane      = MSB_FIRST ? (IDX_W'(BPW - 1) - idx) : idx;

  // Only the addressed lane is written; the others keep the bytes already packed.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else begin
      if (restart)
        idx <= '0;
      else if (advance)
        idx <= last_lane ? '0 : idx + IDX_W'(1);
      if (capture)
        word[{lane, 3'b000} +: 8] <= byte_in;
    end
  end

endmodule

// File: rtl/uart_sram_loader.sv
// Pulls bytes from the UART receiver, strips header lines and writes packed words to SRAM.
// Optional macro UART_SRAM_LOADER_CHECKSUM_EN adds a 16-bit payload byte sum output.
module uart_sram_loader
  import uart_sram_loader_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 18,
  parameter int HEADER_LINES = 0,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       Initialize,
  input  logic                       Enable,
  input  logic [ADDR_W-1:0]          Start_address,
  input  logic [ADDR_W-1:0]          Word_limit,
  input  logic [7:0]                 Rx_data,
  input  logic                       Rx_empty,
  output logic                       Rx_enable,
  output logic                       Rx_unload,
  output logic [ADDR_W-1:0]          SRAM_address,
  output logic [DATA_W-1:0]          SRAM_write_data,
  output logic                       SRAM_we_n,
  output logic                       Busy,
  output logic                       Done,
  output logic [ADDR_W-1:0]          Words_written,
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
  output logic [15:0]                Checksum,
`endif
  output uart_sram_loader_state_type State
);

  localparam logic [2:0] HDR_N = 3'(HEADER_LINES);

  logic [ADDR_W-1:0] limit;
  logic [2:0]        hdr_cnt;
  logic [ADDR_W-1:0] words_next;
  logic              stop;
  logic              start_req;
  logic              capture;
  logic              advance;
  logic              last_lane;

  assign start_req  = Enable && (State == S_IDLE || State == S_DONE);
  assign capture    = (State == S_BYTE_WAIT) && !Rx_empty && !Initialize;
  assign advance    = (State == S_BYTE_ACK) && Rx_empty && !Initialize;
  assign words_next = Words_written + ADDR_W'(1);
  // The address saturates at the top of the space rather than wrapping.
  assign stop       = ((limit != '0) && (words_next == limit)) || (&SRAM_address);

  uart_sram_loader_byte_packer #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_packer (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .clear    (Initialize),
    .restart  (start_req),
    .capture  (capture),
    .advance  (advance),
    .byte_in  (Rx_data),
    .word     (SRAM_write_data),
    .last_lane(last_lane)
  );

  // Handshake: a byte is taken when Rx_empty=0 by raising Rx_unload, which drops only once
  // the receiver reports Rx_empty=1, so exactly one byte is consumed per unload pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      State         <= S_IDLE;
      Rx_enable     <= 1'b0;
      Rx_unload     <= 1'b0;
      SRAM_address  <= '0;
      SRAM_we_n     <= 1'b1;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Words_written <= '0;
      limit         <= '0;
      hdr_cnt       <= '0;
    end else if (Initialize) begin
      State         <= S_IDLE;
      Rx_enable     <= 1'b0;
      Rx_unload     <= 1'b0;
      SRAM_address  <= '0;
      SRAM_we_n     <= 1'b1;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Words_written <= '0;
      limit         <= '0;
      hdr_cnt       <= '0;
    end else begin
      case (State)
        S_IDLE, S_DONE: begin
          if (Enable) begin
            SRAM_address  <= Start_address;
            limit         <= Word_limit;
            Rx_enable     <= 1'b1;
            Words_written <= '0;
            hdr_cnt       <= '0;
            Busy          <= 1'b1;
            Done          <= 1'b0;
            State         <= (HEADER_LINES > 0) ? S_HDR_WAIT : S_BYTE_WAIT;
          end
        end
        S_HDR_WAIT: begin
          if (!Rx_empty) begin
            Rx_unload <= 1'b1;
            if (Rx_data == ASCII_LF && hdr_cnt != HDR_N)
              hdr_cnt <= hdr_cnt + 3'd1;
            State <= S_HDR_ACK;
          end
        end
        S_HDR_ACK: begin
          if (Rx_empty) begin
            Rx_unload <= 1'b0;
            State     <= (hdr_cnt == HDR_N) ? S_BYTE_WAIT : S_HDR_WAIT;
          end
        end
        S_BYTE_WAIT: begin
          if (!Rx_empty) begin
            Rx_unload <= 1'b1;
            State     <= S_BYTE_ACK;
          end
        end
        S_BYTE_ACK: begin
          if (Rx_empty) begin
            Rx_unload <= 1'b0;
            if (last_lane) begin
              SRAM_we_n <= 1'b0;
              State     <= S_WRITE;
            end else begin
              State <= S_BYTE_WAIT;
            end
          end
        end
        S_WRITE: begin
          SRAM_we_n     <= 1'b1;
          Words_written <= words_next;
          if (stop) begin
            Rx_enable <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            State     <= S_DONE;
          end else begin
            SRAM_address <= SRAM_address + ADDR_W'(1);
            State        <= S_BYTE_WAIT;
          end
        end
        default: begin
          State     <= S_IDLE;
          Rx_enable <= 1'b0;
          Rx_unload <= 1'b0;
          SRAM_we_n <= 1'b1;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_SRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      Checksum <= '0;
    else if (Initialize || start_req)
      Checksum <= '0;
    else if (capture)
      Checksum <= Checksum + {8'h00, Rx_data};
  end
`endif

endmodule

// File: tb/tb_uart_sram_loader.sv
// Bench for uart_sram_loader: a 16-bit MSB-first instance and a 32-bit LSB-first instance with
// three header lines, driven by a one-byte UART model and checked against a stream-level model.
`timescale 1ns/1ps
module tb_uart_sram_loader;
  import uart_sram_loader_pkg::*;

  localparam int AW = 18;
  localparam int W  = AW + 64;

  // clock / reset
  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  logic          initialize, enable, sel;
  logic [AW-1:0] start_address, word_limit;
  logic [7:0]    rx_data;
  logic          rx_empty;

  logic rx_enable_a, rx_unload_a, we_n_a, busy_a, done_a;
  logic rx_enable_b, rx_unload_b, we_n_b, busy_b, done_b;
  logic [AW-1:0] addr_a, ww_a, addr_b, ww_b;
  logic [15:0] wd_a;
  logic [31:0] wd_b;
  uart_sram_loader_state_type state_a, state_b;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
  logic [15:0] chk_a, chk_b, cur_chk;
`endif

  uart_sram_loader #(.DATA_W(16), .ADDR_W(AW), .HEADER_LINES(0), .MSB_FIRST(1'b1)) u_dut_a (
    .Clock(Clock), .Resetn(Resetn), .Initialize(initialize), .Enable(enable & ~sel),
    .Start_address(start_address), .Word_limit(word_limit), .Rx_data(rx_data),
    .Rx_empty(rx_empty | sel), .Rx_enable(rx_enable_a), .Rx_unload(rx_unload_a),
    .SRAM_address(addr_a), .SRAM_write_data(wd_a), .SRAM_we_n(we_n_a), .Busy(busy_a),
    .Done(done_a), .Words_written(ww_a),
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    .Checksum(chk_a),
`endif
    .State(state_a));

  uart_sram_loader #(.DATA_W(32), .ADDR_W(AW), .HEADER_LINES(3), .MSB_FIRST(1'b0)) u_dut_b (
    .Clock(Clock), .Resetn(Resetn), .Initialize(initialize), .Enable(enable & sel),
    .Start_address(start_address), .Word_limit(word_limit), .Rx_data(rx_data),
    .Rx_empty(rx_empty | ~sel), .Rx_enable(rx_enable_b), .Rx_unload(rx_unload_b),
    .SRAM_address(addr_b), .SRAM_write_data(wd_b), .SRAM_we_n(we_n_b), .Busy(busy_b),
    .Done(done_b), .Words_written(ww_b),
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    .Checksum(chk_b),
`endif
    .State(state_b));

  logic [AW-1:0] cur_addr, cur_ww;
  logic [63:0]   cur_wdata;
  logic          cur_we_n, cur_busy, cur_done, cur_rx_en, cur_unload;
  logic [2:0]    cur_state;

  always_comb begin
    cur_addr   = sel ? addr_b : addr_a;
    cur_ww     = sel ? ww_b : ww_a;
    cur_wdata  = sel ? {32'h0, wd_b} : {48'h0, wd_a};
    cur_we_n   = sel ? we_n_b : we_n_a;
    cur_busy   = sel ? busy_b : busy_a;
    cur_done   = sel ? done_b : done_a;
    cur_rx_en  = sel ? rx_enable_b : rx_enable_a;
    cur_unload = sel ? rx_unload_b : rx_unload_a;
    cur_state  = sel ? state_b : state_a;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    cur_chk    = sel ? chk_b : chk_a;
`endif
  end

  // one-byte UART receiver model: a byte is removed when the loader raises Rx_unload
  logic [7:0] stream [0:127];
  int stream_len = 0;
  int case_id = 0;
  int seen_id, rx_pos, gap;

  initial begin
    rx_empty = 1'b1; rx_data = 8'h00; seen_id = 0; rx_pos = 0; gap = 0;
    forever begin
      @(negedge Clock);
      if (seen_id != case_id) begin
        seen_id = case_id; rx_pos = 0; rx_empty = 1'b1; gap = 0;
      end else if (cur_unload && !rx_empty) begin
        rx_empty = 1'b1;
      end else if (rx_empty && !cur_unload && rx_pos < stream_len) begin
        if (gap > 0) gap--;
        else begin
          rx_data = stream[rx_pos]; rx_pos++; rx_empty = 1'b0; gap = $urandom_range(0, 2);
        end
      end
    end
  end

  // write-port monitor
  logic [W-1:0] act_q[$];
  int we_long = 0, unload_long = 0;
  initial begin
    bit prev_we_low, prev_unload;
    prev_we_low = 0; prev_unload = 0;
    forever begin
      @(negedge Clock);
      if (Resetn && !cur_we_n) begin
        act_q.push_back({cur_addr, cur_wdata});
        if (prev_we_low) we_long++;
      end
      if (cur_unload && prev_unload) unload_long++;
      prev_we_low = Resetn && !cur_we_n;
      prev_unload = cur_unload;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int tests_run = 0, tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic put(input logic [7:0] b);
    stream[stream_len] = b;
    stream_len++;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle"},
          {cur_addr, cur_wdata, cur_we_n, cur_busy, cur_done, cur_ww, cur_rx_en, cur_unload, cur_state},
          {{AW{1'b0}}, 64'h0, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 3'(S_IDLE)});
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    check({tag, " idle chk"}, cur_chk, 16'h0);
`endif
  endtask

  task automatic run_case(input string name, input logic [AW-1:0] st, input logic [AW-1:0] lim,
                          input bit mid_en);
    int nb, hdr, i, lf, words, pay_start, consumed, cyc, base, we0, ul0, lane;
    bit msb, done;
    logic [AW-1:0] addr;
    logic [63:0] w;
    logic [15:0] sum;
    logic [W-1:0] e, a;
    nb = sel ? 4 : 2; hdr = sel ? 3 : 0; msb = !sel;
    // reference: drop bytes up to the hdr-th LF, then group payload into nb-byte words
    i = 0; lf = 0;
    while (lf < hdr && i < stream_len) begin
      if (stream[i] == 8'h0A) lf++;
      i++;
    end
    pay_start = i; words = 0; addr = st; done = 0;
    if (lf == hdr) begin
      while (!done && i + nb <= stream_len) begin
        w = '0;
        for (int b = 0; b < nb; b++) begin
          lane = msb ? nb - 1 - b : b;
          w[lane*8 +: 8] = stream[i + b];
        end
        exp_q.push_back({addr, w});
        i += nb; words++;
        if ((lim != 0 && words == int'(lim)) || addr == '1) done = 1;
        else addr = addr + 1'b1;
      end
    end
    consumed = done ? i : stream_len;
    sum = '0;
    if (lf == hdr) for (int k = pay_start; k < consumed; k++) sum = sum + {8'h00, stream[k]};

    base = act_q.size(); we0 = we_long; ul0 = unload_long;
    case_id++;
    tick();
    start_address = st; word_limit = lim; enable = 1'b1;
    tick();
    enable = 1'b0;
    start_address = AW'($urandom); word_limit = AW'($urandom);
    if (mid_en) begin
      tick(); enable = 1'b1; tick(); enable = 1'b0;
    end
    cyc = 0;
    if (done) begin
      while (!cur_done && cyc < 3000) begin tick(); cyc++; end
    end else begin
      while (!(rx_pos == stream_len && rx_empty && !cur_unload) && cyc < 3000) begin tick(); cyc++; end
      repeat (6) tick();
    end
    check({name, " settled"}, 128'(cyc < 3000), 128'(1));
    check({name, " nwrites"}, 128'(act_q.size() - base), 128'(exp_q.size()));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = (base + k < act_q.size()) ? act_q[base + k] : 'x;
      check({name, " write"}, a, e);
    end
    check({name, " status"}, {cur_ww, cur_addr, cur_done, cur_busy, cur_rx_en, cur_state},
          {AW'(words), addr, done, !done, !done, done ? 3'(S_DONE) : 3'(S_BYTE_WAIT)});
    check({name, " we_n pulse"}, 128'(we_long - we0), 128'(0));
    check({name, " unload pulse"}, 128'(unload_long - ul0), 128'(0));
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    check({name, " checksum"}, cur_chk, sum);
`endif
    if (!done) begin
      initialize = 1'b1; tick(); initialize = 1'b0;
      check_idle({name, " init"});
    end
  endtask

  initial begin
    logic [AW-1:0] st, lim;
    int np;
    Resetn = 1'b0; initialize = 1'b0; enable = 1'b0; sel = 1'b0;
    start_address = '0; word_limit = '0;
    repeat (3) tick();
    check_idle("reset A");
    sel = 1'b1; #1;
    check_idle("reset B");
    Resetn = 1'b1; tick();

    // 16-bit MSB-first: two words then stop on the limit
    sel = 1'b0;
    stream_len = 0; put(8'hAB); put(8'hCD); put(8'h12); put(8'h34);
    run_case("t1", 18'h0, 18'd2, 1'b0);
    // top of address space, limit 0: two writes then stop without wrapping
    stream_len = 0; for (int k = 0; k < 6; k++) put(8'(8'h10 + k));
    run_case("t4", 18'h3FFFE, 18'd0, 1'b1);
    stream_len = 0; put(8'hFF); put(8'hFF); put(8'h02); put(8'h00);
    run_case("t6", 18'h40, 18'd2, 1'b0);
    // Initialize after the first byte of a word, then a clean restart
    stream_len = 0; put(8'hAB);
    run_case("t5", 18'h5, 18'd3, 1'b0);
    stream_len = 0; put(8'h5A); put(8'hA5);
    run_case("t5r", 18'h7, 18'd1, 1'b0);

    // 32-bit LSB-first with three header lines
    sel = 1'b1; tick();
    stream_len = 0; put_str("P6\n4 4\n255\n"); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    run_case("t2", 18'h100, 18'd1, 1'b0);
    stream_len = 0; put_str("\n\n\n"); put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    run_case("t3", 18'h200, 18'd1, 1'b1);
    stream_len = 0; put_str("\n\n\n"); put(8'h11); put(8'h22); put(8'h33);
    run_case("t3p", 18'h300, 18'd1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      sel = 1'($urandom_range(0, 1)); tick();
      stream_len = 0;
      if (sel) for (int h = 0; h < 3; h++) begin
        repeat ($urandom_range(0, 4)) put(8'($urandom_range(32, 126)));
        put(8'h0A);
      end
      np = $urandom_range(0, (sel ? 4 : 2) * 4 + 3);
      repeat (np) put(8'($urandom));
      st  = ($urandom_range(0, 3) == 0) ? AW'(18'h3FFFF - $urandom_range(0, 3)) : AW'($urandom);
      lim = AW'($urandom_range(0, 4));
      run_case("rand", st, lim, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
